// File: rtl/mem_read_arbiter.sv
// Two-requester round-robin arbiter sharing one burst-read port, with abort/drain support.
// Optional performance counters are enabled by defining MEM_READ_ARB_PERF_EN.
module mem_read_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [LEN_WIDTH-1:0]  m0_len,
  input  logic                  m0_abort,
  input  logic                  m1_req,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [LEN_WIDTH-1:0]  m1_len,
  input  logic                  m1_abort,
  output logic                  m0_rvalid,
  output logic                  m0_rlast,
  output logic                  m1_rvalid,
  output logic                  m1_rlast,
  output logic [31:0]           m_rdata,
  output logic                  d_req,
  output logic [ADDR_WIDTH-1:0] d_addr,
  output logic [LEN_WIDTH-1:0]  d_len,
  input  logic                  d_rvalid,
  input  logic [31:0]           d_rdata,
  input  logic                  d_rlast
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e                state_q, state_d;
  logic                  pend0_q, pend0_d, pend1_q, pend1_d;
  logic [ADDR_WIDTH-1:0] addr0_q, addr0_d, addr1_q, addr1_d;
  logic [LEN_WIDTH-1:0]  len0_q, len0_d, len1_q, len1_d;
  logic                  last_grant_q, last_grant_d;
  logic                  owner_q, owner_d;
  logic                  drop_q, drop_d;
  logic                  d_req_q, d_req_d;
  logic [ADDR_WIDTH-1:0] d_addr_q, d_addr_d;
  logic [LEN_WIDTH-1:0]  d_len_q, d_len_d;

  logic                  busy;
  logic                  acc0, acc1, cand0, cand1, grant, win;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [LEN_WIDTH-1:0]  win_len;

  assign busy = (state_q == StBusy);

  always_comb begin
    // A new pulse is accepted only if that requester has nothing pending or in flight
    acc0  = m0_req & ~m0_abort & ~pend0_q & ~(busy & ~owner_q);
    acc1  = m1_req & ~m1_abort & ~pend1_q & ~(busy & owner_q);
    cand0 = ~busy & ~m0_abort & (pend0_q | m0_req);
    cand1 = ~busy & ~m1_abort & (pend1_q | m1_req);
    grant = cand0 | cand1;
    win   = (cand0 & cand1) ? ~last_grant_q : cand1;
    if (win) begin
      win_addr = pend1_q ? addr1_q : m1_addr;
      win_len  = pend1_q ? len1_q  : m1_len;
    end else begin
      win_addr = pend0_q ? addr0_q : m0_addr;
      win_len  = pend0_q ? len0_q  : m0_len;
    end
  end

  always_comb begin
    state_d      = state_q;
    pend0_d      = pend0_q;
    pend1_d      = pend1_q;
    addr0_d      = addr0_q;
    addr1_d      = addr1_q;
    len0_d       = len0_q;
    len1_d       = len1_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    drop_d       = drop_q;
    d_req_d      = 1'b0;
    d_addr_d     = d_addr_q;
    d_len_d      = d_len_q;

    if (acc0) begin
      pend0_d = 1'b1;
      addr0_d = m0_addr;
      len0_d  = m0_len;
    end
    if (acc1) begin
      pend1_d = 1'b1;
      addr1_d = m1_addr;
      len1_d  = m1_len;
    end

    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d      = StBusy;
          d_req_d      = 1'b1;
          d_addr_d     = win_addr;
          d_len_d      = win_len;
          owner_d      = win;
          last_grant_d = win;
          drop_d       = 1'b0;
          if (win) pend1_d = 1'b0;
          else     pend0_d = 1'b0;
        end
      end
      StBusy: begin
        if ((owner_q ? m1_abort : m0_abort)) drop_d = 1'b1;
        if (d_rvalid && d_rlast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (m0_abort) pend0_d = 1'b0;
    if (m1_abort) pend1_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      pend0_q      <= 1'b0;
      pend1_q      <= 1'b0;
      addr0_q      <= '0;
      addr1_q      <= '0;
      len0_q       <= '0;
      len1_q       <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      drop_q       <= 1'b0;
      d_req_q      <= 1'b0;
      d_addr_q     <= '0;
      d_len_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend0_q      <= pend0_d;
      pend1_q      <= pend1_d;
      addr0_q      <= addr0_d;
      addr1_q      <= addr1_d;
      len0_q       <= len0_d;
      len1_q       <= len1_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      drop_q       <= drop_d;
      d_req_q      <= d_req_d;
      d_addr_q     <= d_addr_d;
      d_len_q      <= d_len_d;
    end
  end

  assign d_req  = d_req_q;
  assign d_addr = d_addr_q;
  assign d_len  = d_len_q;

  // Beats pass straight through; an abort suppresses them in its own cycle too
  always_comb begin
    m0_rvalid = busy & ~owner_q & d_rvalid & ~drop_q & ~m0_abort;
    m1_rvalid = busy &  owner_q & d_rvalid & ~drop_q & ~m1_abort;
    m0_rlast  = m0_rvalid & d_rlast;
    m1_rlast  = m1_rvalid & d_rlast;
    m_rdata   = d_rdata;
  end

`ifdef MEM_READ_ARB_PERF_EN
  logic [63:0] perf_grant_cnt0, perf_grant_cnt1;
  logic [63:0] perf_wait_cycles0, perf_wait_cycles1;
  logic [63:0] perf_drop_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_grant_cnt0   <= '0;
      perf_grant_cnt1   <= '0;
      perf_wait_cycles0 <= '0;
      perf_wait_cycles1 <= '0;
      perf_drop_cnt     <= '0;
    end else begin
      if (grant && !win) perf_grant_cnt0 <= perf_grant_cnt0 + 64'd1;
      if (grant && win)  perf_grant_cnt1 <= perf_grant_cnt1 + 64'd1;
      if (pend0_q && !(grant && !win)) perf_wait_cycles0 <= perf_wait_cycles0 + 64'd1;
      if (pend1_q && !(grant && win))  perf_wait_cycles1 <= perf_wait_cycles1 + 64'd1;
      if (busy && (owner_q ? m1_abort : m0_abort)) perf_drop_cnt <= perf_drop_cnt + 64'd1;
    end
  end
`endif

endmodule
